// File: rtl/str_cic_upsampler.sv
// Streaming CIC interpolator: N combs, R-fold zero-stuffing expander, N integrators,
// followed by a fixed gain-compensation multiply for unity DC gain.
module str_cic_upsampler #(
    parameter int unsigned W = 10,
    parameter int unsigned R = 4,
    parameter int unsigned M = 2,
    parameter int unsigned N = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic signed [W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready
);

    function automatic longint unsigned ipow(longint unsigned b, int unsigned e);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    localparam longint unsigned GAIN = ipow(64'(R * M), N) / 64'(R);
    localparam int unsigned     DW   = W + 32'($clog2(GAIN));
    localparam int unsigned     AW   = DW + 1;
    localparam int unsigned     PW   = 2 * DW + 1;
    localparam int unsigned     CW   = (R > 1) ? 32'($clog2(R)) : 1;
    localparam longint unsigned ATTN = ((64'd1 << (DW - 1)) + GAIN / 2) / GAIN;
    localparam logic signed [AW-1:0] ATTN_S = AW'(ATTN);

    typedef logic signed [DW-1:0] dw_t;

    dw_t            comb_q [N];
    logic [N-1:0]   comb_vld;
    logic [N-1:0]   comb_rdy;
    dw_t            int_q  [N];
    logic [N-1:0]   int_vld;
    logic [N-1:0]   int_rdy;

    dw_t            exp_q,   exp_q_d;
    logic           exp_vld, exp_vld_d;
    logic [CW-1:0]  exp_cnt, exp_cnt_d;
    logic           exp_rdy;

    // A stage can accept when any downstream stage has a bubble or the chain drains.
    for (genvar k = 0; k < N; k++) begin : g_rdy
        assign int_rdy[k]  = m_axis_tready | ~(&int_vld[N-1:k]);
        assign comb_rdy[k] = exp_rdy | ~(&comb_vld[N-1:k]);
    end

    assign exp_rdy = (exp_cnt == '0) & (~exp_vld | int_rdy[0]);

    for (genvar k = 0; k < N; k++) begin : g_comb
        dw_t  din;
        logic din_vld;
        logic ordy;
        dw_t  q;
        logic vld;
        dw_t  dly [M];

        if (k == 0) begin : g_src
            assign din     = DW'(s_axis_tdata);
            assign din_vld = s_axis_tvalid;
        end else begin : g_src
            assign din     = comb_q[k-1];
            assign din_vld = comb_vld[k-1];
        end

        if (k == N - 1) begin : g_dst
            assign ordy = exp_rdy;
        end else begin : g_dst
            assign ordy = comb_rdy[k+1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q   <= '0;
                vld <= 1'b0;
                for (int j = 0; j < M; j++) dly[j] <= '0;
            end else if (din_vld && comb_rdy[k]) begin
                q      <= din - dly[M-1];
                vld    <= 1'b1;
                dly[0] <= din;
                for (int j = 1; j < M; j++) dly[j] <= dly[j-1];
            end else if (ordy) begin
                vld <= 1'b0;
            end
        end

        assign comb_q[k]   = q;
        assign comb_vld[k] = vld;
    end

    // Expander state register; the phase counter doubles as the IDLE/STUFF state.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_cnt <= '0;
            exp_q   <= '0;
            exp_vld <= 1'b0;
        end else begin
            exp_cnt <= exp_cnt_d;
            exp_q   <= exp_q_d;
            exp_vld <= exp_vld_d;
        end
    end

    always_comb begin
        exp_cnt_d = exp_cnt;
        exp_q_d   = exp_q;
        exp_vld_d = exp_vld;
        if (exp_cnt != '0) begin
            if (int_rdy[0]) begin
                exp_q_d   = '0;
                exp_cnt_d = (exp_cnt == CW'(R - 1)) ? '0 : exp_cnt + CW'(1);
            end
        end else if (comb_vld[N-1] && exp_rdy) begin
            exp_q_d   = comb_q[N-1];
            exp_vld_d = 1'b1;
            exp_cnt_d = (R > 1) ? CW'(1) : '0;
        end else if (int_rdy[0]) begin
            exp_vld_d = 1'b0;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_int
        dw_t  din;
        logic din_vld;
        logic ordy;
        dw_t  q;
        logic vld;

        if (k == 0) begin : g_src
            assign din     = exp_q;
            assign din_vld = exp_vld;
        end else begin : g_src
            assign din     = int_q[k-1];
            assign din_vld = int_vld[k-1];
        end

        if (k == N - 1) begin : g_dst
            assign ordy = m_axis_tready;
        end else begin : g_dst
            assign ordy = int_rdy[k+1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q   <= '0;
                vld <= 1'b0;
            end else if (din_vld && int_rdy[k]) begin
                q   <= q + din;
                vld <= 1'b1;
            end else if (ordy) begin
                vld <= 1'b0;
            end
        end

        assign int_q[k]   = q;
        assign int_vld[k] = vld;
    end

    assign s_axis_tready = comb_rdy[0];
    assign m_axis_tvalid = int_vld[N-1];
    // Gain compensation: Q1.(DW-1) multiply, wrap to W bits.
    assign m_axis_tdata  = W'((PW'(int_q[N-1]) * PW'(ATTN_S)) >>> (DW - 1));

endmodule

// File: tb/tb_str_cic_upsampler.sv
// Scoreboard bench for str_cic_upsampler at default parameters (W=10, R=4, M=2, N=2).
module tb_str_cic_upsampler;

    localparam int W  = 10;
    localparam int R  = 4;
    localparam int M  = 2;
    localparam int N  = 2;
    localparam int DW = 14;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] m_data;
    logic                m_valid;
    logic                m_ready;

    str_cic_upsampler #(.W(W), .R(R), .M(M), .N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready)
    );

    int errors = 0;
    int checks = 0;
    int sb[$];
    int obs[$];
    bit capture = 0;
    int mdl_dly [N][M];
    int mdl_acc [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrapn(input longint v, input int bits);
        longint m;
        longint r;
        m = longint'(1) << bits;
        r = v & (m - 1);
        if (r >= m / 2) r = r - m;
        return int'(r);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mdl_acc[k] = 0;
            for (int j = 0; j < M; j++) mdl_dly[k][j] = 0;
        end
    endfunction

    // Reference CIC: comb chain, zero-stuff, integrate, scale by 512/2^13.
    function automatic void model_push(input int x_in);
        int x;
        int y;
        int e;
        x = x_in;
        for (int k = 0; k < N; k++) begin
            y = wrapn(longint'(x) - longint'(mdl_dly[k][M-1]), DW);
            for (int j = M - 1; j > 0; j--) mdl_dly[k][j] = mdl_dly[k][j-1];
            mdl_dly[k][0] = x;
            x = y;
        end
        for (int p = 0; p < R; p++) begin
            e = (p == 0) ? x : 0;
            for (int k = 0; k < N; k++) begin
                mdl_acc[k] = wrapn(longint'(mdl_acc[k]) + longint'(e), DW);
                e = mdl_acc[k];
            end
            sb.push_back(wrapn((longint'(e) * 512) >>> 13, W));
        end
    endfunction

    // Monitor: handshakes are decided by the values held across the negative edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            sb.delete();
        end else begin
            if (s_valid && s_ready) model_push(int'(s_data));
            if (m_valid && m_ready) begin
                check("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) check("sb_data", int'(m_data), sb.pop_front());
                if (capture) obs.push_back(int'(m_data));
            end
        end
    end

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        ticks(1);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            ticks(1);
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic send_one(input int v, input string tag);
        bit acc;
        int n;
        s_data = W'(v);
        s_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        check(tag, int'(acc), 1);
    endtask

    task automatic impulse(input string tag);
        int imp_exp[16] = '{10, 20, 30, 40, 50, 60, 70, 80, 70, 60, 50, 40, 30, 20, 10, 0};
        int lat;
        m_ready = 1'b1;
        obs.delete();
        capture = 1'b1;
        send_one(160, {tag, "_accept"});
        s_data = '0;
        lat = 1;
        while (!(m_valid && m_data != 0) && lat < 30) begin
            ticks(1);
            lat++;
        end
        check({tag, "_latency"}, lat, 2 * N + 1);
        ticks(80);
        capture = 1'b0;
        check({tag, "_len"}, int'(obs.size() >= 16), 1);
        for (int i = 0; i < 16; i++)
            if (i < obs.size()) check($sformatf("%s_seq%0d", tag, i), obs[i], imp_exp[i]);
        drain({tag, "_drain"});
    endtask

    initial begin
        bit acc;
        int n_acc;
        int n_vld;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        ticks(3);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        rst = 1'b0;
        #1;
        check("rst_s_ready", int'(s_ready), 1);

        // DC: steady 100 and one accepted input per R output beats
        s_data = 10'sd100;
        s_valid = 1'b1;
        ticks(30);
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            tick(acc);
            if (acc) n_acc++;
        end
        check("dc_accept_rate", n_acc, 40 / R);
        check("dc_value", int'(m_data), 100);
        check("dc_valid", int'(m_valid), 1);
        drain("dc_drain");

        reset_dut();
        impulse("impulse");

        // Backpressure: random downstream stalls against the same DC stream
        reset_dut();
        s_data = 10'sd100;
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            ticks(1);
        end
        drain("bp_drain");

        // Reset while the expander is emitting zero phases
        reset_dut();
        send_one(160, "mid_accept");
        s_valid = 1'b0;
        ticks(3);
        rst = 1'b1;
        ticks(1);
        check("mid_rst_m_valid", int'(m_valid), 0);
        rst = 1'b0;
        #1;
        check("mid_rst_s_ready", int'(s_ready), 1);
        n_vld = 0;
        for (int i = 0; i < 10; i++) begin
            tick(acc);
            if (m_valid) n_vld++;
        end
        check("mid_rst_no_residue", n_vld, 0);
        impulse("post_rst_impulse");

        // Negative full scale with intermediate integrator wrap
        reset_dut();
        s_data = -10'sd512;
        s_valid = 1'b1;
        ticks(60);
        check("negfs_value", int'(m_data), -512);
        check("negfs_valid", int'(m_valid), 1);
        drain("negfs_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
